// File: rtl/rgb_led_arbiter.sv
// Round-robin owner of the shared RGB LED driver with a minimum display tenure,
// plus the 8-bit PWM generation for the three colour channels.
module rgb_led_arbiter #(
  parameter int unsigned HOLD_CYCLES = 32'd6000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [71:0] req_color,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b
);

  localparam logic [31:0] HOLD_RELOAD = 32'(HOLD_CYCLES - 32'd1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  w_ptr_nxt;
  logic [31:0] r_hold;
  logic [31:0] w_hold_nxt;
  logic [23:0] r_color;
  logic [23:0] w_color_nxt;
  logic [2:0]  r_grant;
  logic [2:0]  w_grant_nxt;
  logic [7:0]  r_cnt;
  logic [23:0] r_duty;
  logic        r_pwm_r;
  logic        r_pwm_g;
  logic        r_pwm_b;
  logic [2:0]  w_pick;
  logic        w_cnt_wrap;
  logic [23:0] w_owner_color;

  function automatic logic [1:0] next3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [23:0] color_of(input logic [71:0] c, input logic [1:0] i);
    case (i)
      2'd0:    return c[23:0];
      2'd1:    return c[47:24];
      default: return c[71:48];
    endcase
  endfunction

  // Returns {found, index}; the pointer itself is only a candidate when incl_self is set.
  function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [2:0] rq,
                                         input logic incl_self);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = next3(p);
    c2 = next3(c1);
    if (rq[c1]) return {1'b1, c1};
    if (rq[c2]) return {1'b1, c2};
    if (incl_self && rq[p]) return {1'b1, p};
    return 3'b000;
  endfunction

  assign w_cnt_wrap    = (r_cnt == 8'hFF);
  assign w_owner_color = color_of(req_color, r_ptr);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_color_nxt = r_color;
    w_grant_nxt = r_grant;
    w_pick      = 3'b000;
    unique case (r_state)
      S_IDLE: begin
        w_color_nxt = '0;
        w_grant_nxt = '0;
        w_pick      = rr_pick(r_ptr, req, 1'b1);
      end
      S_OWN: begin
        if (w_cnt_wrap && req[r_ptr]) w_color_nxt = w_owner_color;
        if (r_hold != 32'd0) begin
          w_hold_nxt = r_hold - 32'd1;
        end else begin
          w_pick = rr_pick(r_ptr, req, 1'b0);
          if (!w_pick[2] && !req[r_ptr]) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_color_nxt = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A new grant (from idle or a rotation) overrides any boundary colour copy.
    if (w_pick[2]) begin
      w_state_nxt = S_OWN;
      w_ptr_nxt   = w_pick[1:0];
      w_hold_nxt  = HOLD_RELOAD;
      w_color_nxt = color_of(req_color, w_pick[1:0]);
      w_grant_nxt = 3'b001 << w_pick[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd2;
      r_hold  <= '0;
      r_color <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_duty  <= '0;
      r_pwm_r <= 1'b0;
      r_pwm_g <= 1'b0;
      r_pwm_b <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_color <= w_color_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= r_cnt + 8'd1;
      // Duties take the colour as it stands after this edge, so they apply from cnt==0.
      if (w_cnt_wrap) r_duty <= w_color_nxt;
      r_pwm_r <= (r_cnt < r_duty[23:16]);
      r_pwm_g <= (r_cnt < r_duty[15:8]);
      r_pwm_b <= (r_cnt < r_duty[7:0]);
    end
  end

  assign grant = r_grant;
  assign busy  = |r_grant;
  assign pwm_r = r_pwm_r;
  assign pwm_g = r_pwm_g;
  assign pwm_b = r_pwm_b;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Randomised and directed bench for rgb_led_arbiter against a cycle-level behavioural model.
module tb_rgb_led_arbiter;

  localparam int HOLD = 1000;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [71:0] req_color;
  logic [2:0]  grant;
  logic        busy;
  logic        pwm_r;
  logic        pwm_g;
  logic        pwm_b;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: owner index (-1 idle), cycles spent in current tenure.
  int          m_owner;
  int          m_last;
  int          m_ten;
  int          m_cnt;
  logic [23:0] m_col;
  logic [23:0] m_duty;
  logic [2:0]  m_pwm;

  rgb_led_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .req       (req),
    .req_color (req_color),
    .grant     (grant),
    .busy      (busy),
    .pwm_r     (pwm_r),
    .pwm_g     (pwm_g),
    .pwm_b     (pwm_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] colr(input int i);
    return req_color[24*i +: 24];
  endfunction

  function automatic logic [2:0] m_grant();
    return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
  endfunction

  task automatic model_step();
    logic [23:0] ncol;
    int pick;
    bit stay;
    if (!rst_n) begin
      m_owner = -1; m_last = 2; m_ten = 0; m_cnt = 0;
      m_col = '0; m_duty = '0; m_pwm = '0;
      return;
    end
    m_pwm = {m_cnt < int'(m_duty[23:16]), m_cnt < int'(m_duty[15:8]), m_cnt < int'(m_duty[7:0])};
    ncol = m_col;
    pick = -1;
    stay = 0;
    if (m_owner < 0) begin
      ncol = '0;
      for (int k = 1; k <= 3; k++)
        if (pick < 0 && req[(m_last + k) % 3]) pick = (m_last + k) % 3;
    end else begin
      if (m_ten < HOLD - 1) begin
        m_ten++;
        stay = 1;
      end else begin
        for (int k = 1; k <= 2; k++)
          if (pick < 0 && req[(m_owner + k) % 3]) pick = (m_owner + k) % 3;
        if (pick < 0) begin
          if (req[m_owner]) stay = 1;
          else begin
            m_owner = -1;
            ncol = '0;
          end
        end
      end
      if (stay && m_cnt == 255 && req[m_owner]) ncol = colr(m_owner);
    end
    if (pick >= 0) begin
      m_owner = pick; m_last = pick; m_ten = 0;
      ncol = colr(pick);
    end
    if (m_cnt == 255) m_duty = ncol;
    m_col = ncol;
    m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("grant", 32'(grant), 32'(m_grant()));
    check("busy",  32'(busy),  32'(m_owner >= 0));
    check("pwm",   32'({pwm_r, pwm_g, pwm_b}), 32'(m_pwm));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    req = 3'b000;
    while (m_owner >= 0 && n < 1500) begin
      tick();
      n++;
    end
    check(tag, 32'(grant), 32'd0);
  endtask

  initial begin
    int run, seg, cr, cg, cb, n;
    logic [2:0] cur;
    logic [2:0] rr_seq [4];
    logic [23:0] exp_col;
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;

    // Reset held with every requester asking.
    rst_n = 1'b0;
    req = 3'b111;
    req_color = 72'hA1B2C3_445566_8000FF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_grant", 32'(grant), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("rst_first", 32'(grant), 32'b001);

    // Full contention: exact tenures, strict rotation, no gaps.
    cur = grant; run = 1; seg = 0; n = 0;
    while (seg < 3 && n < 3100) begin
      tick();
      n++;
      if (grant == cur) run++;
      else begin
        check("rr_len", 32'(run), 32'(HOLD));
        check("rr_next", 32'(grant), 32'(rr_seq[seg + 1]));
        seg++;
        cur = grant;
        run = 1;
      end
    end
    check("rr_segments", 32'(seg), 32'd3);
    wait_idle("idle_a");

    // Single requester, duty measurement.
    req_color[23:0] = 24'h8000FF;
    req = 3'b001;
    tick();
    check("req0_grant", 32'(grant), 32'b001);
    for (int i = 0; i < 600; i++) tick();
    cr = 0; cg = 0; cb = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      cr += int'(pwm_r); cg += int'(pwm_g); cb += int'(pwm_b);
    end
    check("duty_r", 32'(cr), 32'd128);
    check("duty_g", 32'(cg), 32'd0);
    check("duty_b", 32'(cb), 32'd255);
    wait_idle("idle_b");
    for (int i = 0; i < 300; i++) tick();
    check("idle_pwm", 32'({pwm_r, pwm_g, pwm_b}), 32'd0);

    // One-cycle pulse from requester 1 still earns a full tenure.
    req_color[47:24] = 24'($urandom);
    req = 3'b010;
    tick();
    exp_col = req_color[47:24];
    check("pulse_grant", 32'(grant), 32'b010);
    req = 3'b000;
    req_color[47:24] = ~exp_col;
    run = 1; cg = 0; n = 0;
    while (grant == 3'b010 && n < 2000) begin
      tick();
      n++;
      if (grant == 3'b010) run++;
      if (grant == 3'b010 && run > 600 && run <= 856) cg += int'(pwm_g);
    end
    check("pulse_len", 32'(run), 32'(HOLD));
    check("pulse_after", 32'(grant), 32'd0);
    check("pulse_color", 32'(cg), 32'(exp_col[15:8]));
    wait_idle("idle_c");

    // Requester 2 arrives mid-tenure; owner 0 keeps the LED for the full hold.
    req = 3'b001;
    tick();
    check("pre_grant", 32'(grant), 32'b001);
    run = 1; n = 0;
    while (grant == 3'b001 && n < 1500) begin
      if (run == 500) req = 3'b101;
      tick();
      n++;
      if (grant == 3'b001) run++;
    end
    check("pre_len", 32'(run), 32'(HOLD));
    check("pre_switch", 32'(grant), 32'b100);

    // Reset in the middle of a tenure at cnt==100.
    n = 0;
    while (m_cnt != 100 && n < 300) begin
      tick();
      n++;
    end
    check("mid_cnt", 32'(m_cnt), 32'd100);
    rst_n = 1'b0;
    req = 3'b111;
    tick();
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_pwm", 32'({pwm_r, pwm_g, pwm_b}), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_first", 32'(grant), 32'b001);

    // Random traffic, colour changes and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 199) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        req_color[31:0]  = $urandom;
        req_color[63:32] = $urandom;
        req_color[71:64] = 8'($urandom_range(0, 255));
      end
      rst_n = ($urandom_range(0, 3999) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
